// File: rtl/lux_scan_scheduler.sv
// Round-robin BH1750 scan: arms one driver at a time, captures its reading, publishes all readings once per fixed-period round.
// Publish lands the cycle after the last sensor's NEXT; no backpressure, a dead sensor costs at most TIMEOUT_CYC per wait phase.
module lux_scan_scheduler #(
   parameter int NUM_SENS    = 4,
   parameter int PERIOD_CYC  = 50_000_000,
   parameter int TIMEOUT_CYC = 25_000_000
) (
   input  logic                     sys_clk,
   input  logic                     _rst,
   input  logic                     en,
   input  logic [NUM_SENS-1:0]      busy,
   input  logic [16*NUM_SENS-1:0]   data_in,
   output logic [NUM_SENS-1:0]      str,
   output logic [16*NUM_SENS-1:0]   lux,
   output logic [2:0]               max_idx,
   output logic [15:0]              max_lux,
   output logic [NUM_SENS-1:0]      err,
   output logic                     valid,
   output logic                     round_busy
);

   typedef enum logic [2:0] {
      IDLE, ARM, WAIT_DONE, CAPTURE, NEXT, PUBLISH, HOLD
   } state_t;

   localparam logic [31:0]         PER_LD  = 32'(PERIOD_CYC - 1);
   localparam logic [31:0]         TMO_LD  = 32'(TIMEOUT_CYC - 1);
   localparam logic [2:0]          LAST    = 3'(NUM_SENS - 1);
   localparam logic [NUM_SENS-1:0] ONE_HOT = {{(NUM_SENS-1){1'b0}}, 1'b1};

   state_t                   state;
   logic [2:0]               idx;
   logic [31:0]              per_cnt;
   logic [31:0]              tmo_cnt;
   logic [16*NUM_SENS-1:0]   sh_lux;
   logic [NUM_SENS-1:0]      sh_err;
   logic [15:0]              mx_val;
   logic [2:0]               mx_idx;
   logic                     mx_vld;

   logic [15:0]              cur_dat;
   logic                     cur_busy;
   logic                     start;

   always_comb begin
      cur_dat  = '0;
      cur_busy = 1'b0;
      for (int i = 0; i < NUM_SENS; i++) begin
         if (idx == 3'(i)) begin
            cur_dat  = data_in[16*i +: 16];
            cur_busy = busy[i];
         end
      end
   end

   // A round starts from IDLE on enable, or from HOLD once the period has elapsed.
   assign start = en && ((state == IDLE) || (state == HOLD && per_cnt == '0));

   always_ff @(posedge sys_clk or negedge _rst) begin
      if (!_rst) begin
         state      <= IDLE;
         idx        <= '0;
         per_cnt    <= '0;
         tmo_cnt    <= '0;
         sh_lux     <= '0;
         sh_err     <= '0;
         mx_val     <= '0;
         mx_idx     <= '0;
         mx_vld     <= 1'b0;
         str        <= '0;
         lux        <= '0;
         max_idx    <= '0;
         max_lux    <= '0;
         err        <= '0;
         valid      <= 1'b0;
         round_busy <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (per_cnt != '0)
            per_cnt <= per_cnt - 32'd1;

         if (state != IDLE && !en) begin
            state      <= IDLE;
            str        <= '0;
            round_busy <= 1'b0;
         end else if (start) begin
            state      <= ARM;
            idx        <= '0;
            str        <= ONE_HOT;
            tmo_cnt    <= TMO_LD;
            per_cnt    <= PER_LD;
            mx_val     <= '0;
            mx_idx     <= '0;
            mx_vld     <= 1'b0;
            sh_err     <= '0;
            round_busy <= 1'b1;
         end else begin
            case (state)
               ARM, WAIT_DONE: begin
                  // The handshake is checked first so it wins over a same-cycle timeout.
                  if (state == ARM && cur_busy) begin
                     state   <= WAIT_DONE;
                     tmo_cnt <= TMO_LD;
                  end else if (state == WAIT_DONE && !cur_busy) begin
                     state <= CAPTURE;
                  end else if (tmo_cnt == '0) begin
                     for (int i = 0; i < NUM_SENS; i++) begin
                        if (idx == 3'(i)) begin
                           sh_err[i]          <= 1'b1;
                           sh_lux[16*i +: 16] <= '0;
                        end
                     end
                     str   <= '0;
                     state <= NEXT;
                  end else begin
                     tmo_cnt <= tmo_cnt - 32'd1;
                  end
               end
               CAPTURE: begin
                  for (int i = 0; i < NUM_SENS; i++) begin
                     if (idx == 3'(i))
                        sh_lux[16*i +: 16] <= cur_dat;
                  end
                  if (!mx_vld || cur_dat > mx_val) begin
                     mx_val <= cur_dat;
                     mx_idx <= idx;
                     mx_vld <= 1'b1;
                  end
                  str   <= '0;
                  state <= NEXT;
               end
               NEXT: begin
                  if (idx == LAST) begin
                     state <= PUBLISH;
                  end else begin
                     idx     <= idx + 3'd1;
                     str     <= ONE_HOT << (idx + 3'd1);
                     tmo_cnt <= TMO_LD;
                     state   <= ARM;
                  end
               end
               PUBLISH: begin
                  lux        <= sh_lux;
                  err        <= sh_err;
                  max_idx    <= mx_idx;
                  max_lux    <= mx_val;
                  valid      <= 1'b1;
                  round_busy <= 1'b0;
                  state      <= HOLD;
               end
               HOLD:    state <= HOLD;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lux_scan_scheduler.sv
// Bench for lux_scan_scheduler: behavioural sensor drivers plus a per-round expectation model.
module tb_lux_scan_scheduler;

   localparam int N   = 4;
   localparam int PER = 2000;
   localparam int TMO = 300;

   logic              sys_clk = 1'b0;
   logic              _rst;
   logic              en;
   logic [N-1:0]      busy;
   logic [16*N-1:0]   data_in;
   logic [N-1:0]      str;
   logic [16*N-1:0]   lux;
   logic [2:0]        max_idx;
   logic [15:0]       max_lux;
   logic [N-1:0]      err;
   logic              valid;
   logic              round_busy;

   lux_scan_scheduler #(.NUM_SENS(N), .PERIOD_CYC(PER), .TIMEOUT_CYC(TMO)) dut (
      .sys_clk(sys_clk), ._rst(_rst), .en(en), .busy(busy), .data_in(data_in),
      .str(str), .lux(lux), .max_idx(max_idx), .max_lux(max_lux), .err(err),
      .valid(valid), .round_busy(round_busy)
   );

   always #5 sys_clk = ~sys_clk;

   int errors = 0;
   int checks = 0;

   // Sensor behaviour: 0 = normal handshake, 1 = never raises busy, 2 = busy stuck high.
   int          mode [N];
   logic [15:0] dval [N];
   int          ph   [N];

   int cyc = 0, nvalid = 0, last_valid_cyc = 0;
   int last_start = 0, prev_start = 0, run2 = 0, last_run2 = 0;
   logic prev_str0 = 1'b0;
   logic [127:0] prev_pub = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge sys_clk);
      #1;
   endtask

   task automatic wait_valid(input int lim);
      int n0 = nvalid;
      for (int k = 0; k < lim && nvalid == n0; k++) step(1);
      if (nvalid == n0) begin
         checks++;
         errors++;
         $display("FAIL wait_valid: no valid pulse within %0d cycles", lim);
      end
   endtask

   // Expected published round: each working sensor reports its data, failed ones report 0 with err set;
   // the brightest working sensor wins, the lowest index on a tie, all-failed gives 0/0.
   function automatic void model(output logic [16*N-1:0] l, output logic [N-1:0] e,
                                 output logic [2:0] mi, output logic [15:0] ml);
      bit found = 0;
      l = '0; e = '0; mi = '0; ml = '0;
      for (int i = 0; i < N; i++) begin
         if (mode[i] != 0) e[i] = 1'b1;
         else begin
            l[16*i +: 16] = dval[i];
            if (!found || dval[i] > ml) begin
               ml = dval[i];
               mi = 3'(i);
               found = 1;
            end
         end
      end
   endfunction

   // Driver models: busy rises 5 cycles after str, stays high 50 cycles.
   initial begin
      busy = '0;
      data_in = '0;
      for (int i = 0; i < N; i++) ph[i] = 0;
      forever begin
         @(negedge sys_clk);
         for (int i = 0; i < N; i++) begin
            if (mode[i] == 2) busy[i] = 1'b1;
            else if (mode[i] == 1) busy[i] = 1'b0;
            else begin
               if (str[i]) ph[i]++;
               else ph[i] = 0;
               busy[i] = (ph[i] >= 5 && ph[i] < 55);
            end
            data_in[16*i +: 16] = dval[i];
         end
      end
   end

   // Per-cycle compare against the model and structural rules.
   initial begin
      logic [16*N-1:0] el;
      logic [N-1:0]    ee;
      logic [2:0]      emi;
      logic [15:0]     eml;
      forever begin
         @(negedge sys_clk);
         cyc++;
         if (_rst) begin
            chk("str_onehot0", 128'($onehot0(str)), 128'd1);
            if (str != '0) chk("round_busy_in_round", 128'(round_busy), 128'd1);
            if (valid) begin
               model(el, ee, emi, eml);
               chk("pub_lux", 128'(lux), 128'(el));
               chk("pub_err", 128'(err), 128'(ee));
               chk("pub_max_idx", 128'(max_idx), 128'(emi));
               chk("pub_max_lux", 128'(max_lux), 128'(eml));
               chk("pub_round_busy_low", 128'(round_busy), 128'd0);
               nvalid++;
               last_valid_cyc = cyc;
            end else begin
               chk("pub_stable", {lux, err, max_idx, max_lux}, prev_pub);
            end
            if (str[0] && !prev_str0) begin
               prev_start = last_start;
               last_start = cyc;
            end
            if (str[2]) run2++;
            else if (run2 != 0) begin
               last_run2 = run2;
               run2 = 0;
            end
         end
         prev_pub  = {lux, err, max_idx, max_lux};
         prev_str0 = str[0];
      end
   end

   initial begin
      int n0, v1, rel;
      _rst = 1'b0;
      en   = 1'b0;
      for (int i = 0; i < N; i++) begin
         mode[i] = 0;
         dval[i] = '0;
      end
      step(3);
      chk("rst_str", 128'(str), 128'd0);
      chk("rst_lux", 128'(lux), 128'd0);
      chk("rst_err", 128'(err), 128'd0);
      chk("rst_valid", 128'(valid), 128'd0);
      chk("rst_round_busy", 128'(round_busy), 128'd0);
      chk("rst_max", {max_idx, max_lux}, 128'd0);
      _rst = 1'b1;
      step(2);

      // Normal round.
      dval[0] = 16'h0100; dval[1] = 16'h0500; dval[2] = 16'h0300; dval[3] = 16'h0050;
      en = 1'b1;
      wait_valid(3000);
      chk("t1_lux", 128'(lux), 128'h0050_0300_0500_0100);
      chk("t1_max_idx", 128'(max_idx), 128'd1);
      chk("t1_max_lux", 128'(max_lux), 128'h0500);
      chk("t1_err", 128'(err), 128'd0);
      chk("t1_nvalid", 128'(nvalid), 128'd1);
      en = 1'b0;
      step(5);
      chk("t1_idle_str", 128'(str), 128'd0);

      // Sensor 2 dead.
      mode[2] = 1;
      en = 1'b1;
      wait_valid(3000);
      chk("t2_err", 128'(err), 128'b0100);
      chk("t2_lux2", 128'(lux[47:32]), 128'd0);
      chk("t2_max_idx", 128'(max_idx), 128'd1);
      chk("t2_str2_len", 128'(last_run2), 128'(TMO));
      wait_valid(3000);
      chk("t2_period", 128'(last_start - prev_start), 128'(PER));
      en = 1'b0;
      step(5);
      mode[2] = 0;

      // Tie between sensors 0 and 3.
      dval[0] = 16'h0800; dval[1] = 16'h0200; dval[2] = 16'h0100; dval[3] = 16'h0800;
      en = 1'b1;
      wait_valid(3000);
      chk("t3_max_idx", 128'(max_idx), 128'd0);
      chk("t3_max_lux", 128'(max_lux), 128'h0800);

      // Enable dropped while sensor 1 is in its wait phase.
      dval[0] = 16'h0111; dval[1] = 16'h0222; dval[2] = 16'h0333; dval[3] = 16'h0444;
      begin
         int k = 0;
         while (!(str[1] && busy[1]) && k < 5000) begin step(1); k++; end
         chk("t5_reach_wait", 128'(str[1] && busy[1]), 128'd1);
      end
      step(3);
      en = 1'b0;
      step(1);
      chk("t5_str_off", 128'(str), 128'd0);
      chk("t5_rb_off", 128'(round_busy), 128'd0);
      n0 = nvalid;
      step(100);
      chk("t5_no_valid", 128'(nvalid), 128'(n0));
      chk("t5_lux_kept", 128'(lux), 128'h0800_0100_0200_0800);
      en = 1'b1;
      step(1);
      chk("t5_restart_s0", 128'(str), 128'b0001);
      wait_valid(3000);
      chk("t5_max_idx", 128'(max_idx), 128'd3);
      chk("t5_max_lux", 128'(max_lux), 128'h0444);
      en = 1'b0;
      step(5);

      // All sensors stuck busy.
      for (int i = 0; i < N; i++) mode[i] = 2;
      en = 1'b1;
      wait_valid(3000);
      chk("t4_err", 128'(err), 128'b1111);
      chk("t4_max", {max_idx, max_lux}, 128'd0);
      v1 = last_valid_cyc;
      wait_valid(3000);
      chk("t4_valid_period", 128'(last_valid_cyc - v1), 128'(PER));
      en = 1'b0;
      step(5);
      for (int i = 0; i < N; i++) mode[i] = 0;

      // Reset mid-round.
      dval[0] = 16'h1234; dval[1] = 16'h0042; dval[2] = 16'h2222; dval[3] = 16'h0007;
      en = 1'b1;
      step(100);
      _rst = 1'b0;
      #1;
      chk("t6_rst_outs", {str, err, valid, round_busy, max_idx, max_lux}, 128'd0);
      chk("t6_rst_lux", 128'(lux), 128'd0);
      step(2);
      _rst = 1'b1;
      rel = cyc;
      wait_valid(3000);
      chk("t6_full_round", 128'((cyc - rel) >= 4 * 55), 128'd1);
      chk("t6_max_idx", 128'(max_idx), 128'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lux_scan_scheduler.md
Name: lux_scan_scheduler

Overview:
- Sequences up to NUM_SENS BH1750 light-sensor drivers, one measurement at a time, for the HelioSmart tracker.
- Drives each driver's start-enable line (str), waits on its busy handshake and captures the 16-bit reading.
- Once per round, publishes all readings, the brightest sensor index and per-sensor error flags to the tracking logic.
- Enforces a fixed round period and per-sensor timeouts, so a dead sensor cannot stall the tracker.

Parameters:
- NUM_SENS, 4, number of sensor drivers scheduled (2..8).
- PERIOD_CYC, 50_000_000, sys_clk cycles from one round start to the next.
- TIMEOUT_CYC, 25_000_000, maximum sys_clk cycles allowed per wait phase before the sensor is declared failed.

Ports:
- sys_clk  in  1  system clock.
- _rst  in  1  asynchronous active-low reset.
- en  in  1  scheduler enable, level.
- busy  in  NUM_SENS  busy outputs of the sensor drivers.
- data_in  in  16*NUM_SENS  driver readings; sensor i occupies bits [16i+15:16i].
- str  out  NUM_SENS  per-driver start enable; at most one bit is high at any time.
- lux  out  16*NUM_SENS  published readings, same packing as data_in.
- max_idx  out  3  index of the brightest valid sensor.
- max_lux  out  16  reading at max_idx.
- err  out  NUM_SENS  timeout flag per sensor for the last published round.
- valid  out  1  one-cycle pulse when lux/max_*/err update.
- round_busy  out  1  high from round start until PUBLISH completes.

Behaviour:
- Reset (async, _rst=0):
  - all outputs 0;
  - state IDLE, index 0, period and timeout counters 0;
  - shadow registers (readings, running max, error flags) 0.
- States: IDLE, ARM, WAIT_DONE, CAPTURE, NEXT, PUBLISH, HOLD.
- IDLE:
  - str=0.
  - When en=1, next cycle → ARM with idx=0.
  - On leaving IDLE: clear running max and shadow errors, load period counter, assert round_busy.
- ARM:
  - str[idx]=1; timeout counter runs.
  - busy[idx]=1 → WAIT_DONE, timeout counter reloaded.
  - Timeout expiry → shadow err[idx]=1, shadow reading=0, → NEXT.
- WAIT_DONE:
  - str[idx] stays 1.
  - busy[idx]=0 → CAPTURE.
  - Timeout expiry → err[idx]=1, reading=0, → NEXT.
- CAPTURE (1 cycle):
  - shadow[idx] <= data_in[idx]; str[idx] <= 0.
  - Max compare: if no valid max yet, or data strictly greater than running max, update max value and index. Ties keep the lower index.
  - → NEXT.
- NEXT (1 cycle):
  - str all 0.
  - idx == NUM_SENS-1 → PUBLISH; otherwise idx+1 → ARM.
  - The one-cycle gap guarantees the driver sees str low before the next sensor is armed.
- PUBLISH (1 cycle):
  - Copy shadows to lux, err, max_idx, max_lux; valid=1; round_busy <= 0; → HOLD.
  - If every sensor errored: max_idx=0, max_lux=0.
- HOLD:
  - Wait until the period counter reaches 0, then → ARM (idx=0, round restart as above).
  - If the round already exceeded PERIOD_CYC, restart on the cycle after PUBLISH.
  - The period counter decrements every cycle from round start and saturates at 0.
- en deasserted in any non-IDLE state:
  - next cycle: str=0, → IDLE, round_busy=0, no valid pulse;
  - published outputs keep their prior values.
- Simultaneous busy edge and timeout expiry in the same cycle: the handshake wins (no error).
- Published outputs change only in PUBLISH or at reset.
- Counters are 32-bit, down-counting.
- The busy input is treated as synchronous to sys_clk.

Test Plan:
- NUM_SENS=4, PERIOD_CYC=2000, TIMEOUT_CYC=300; models raise busy 5 cycles after str and drop it 50 cycles later with data 0x0100/0x0500/0x0300/0x0050 → one valid pulse, lux matches, max_idx=1, max_lux=0x0500, err=0000, only one str bit high at any time.
- Sensor 2 never raises busy → str[2] drops after 300 cycles, err=0100, lux[2]=0, max_idx=1; round still publishes; next round starts 2000 cycles after the previous start.
- Sensors 0 and 3 both read 0x0800 → max_idx=0, max_lux=0x0800.
- All sensors hold busy high forever → err=1111, max_idx=0, max_lux=0, valid pulses once per round.
- en dropped while in WAIT_DONE of sensor 1 → str=0 next cycle, no valid, lux unchanged from the previous round; en re-raised → round restarts at sensor 0.
- _rst asserted mid-round → all outputs 0 immediately; after release with en=1, the first valid pulse appears after one full round.
